// File: rtl/axi_pkg.sv
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared types, AXI constants and the write-strobe helper for
//                the SRAM-like to AXI bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;

    localparam logic [3:0] c_ID_INST = 4'd0;
    localparam logic [3:0] c_ID_DATA = 4'd1;

    // Size 3 is illegal on the CPU side and falls back to a full word.
    function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
        case (size)
            2'd0:    return 4'b0001 << addr_lo;
            2'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_to_axi.sv
// ============================================================================
//  Module      : sram_like_to_axi
//  Description : Merges the instruction and data SRAM-like ports onto one
//                single-outstanding AXI master; data has priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_to_axi
    import axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      r_state;
    owner_t      r_owner;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_idle;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_resp_ok;
    logic        w_unused;

    assign w_idle  = (r_state == IDLE) && !rst;
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;

    assign data_addr_ok = w_idle && data_req;
    assign inst_addr_ok = w_idle && inst_req && !data_req;

    assign w_resp_ok    = !rst && (((r_state == RD_DATA) && rvalid) ||
                                   ((r_state == WR_RESP) && bvalid));
    assign data_data_ok = w_resp_ok && (r_owner == OWNER_DATA);
    assign inst_data_ok = w_resp_ok && (r_owner == OWNER_INST);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = (r_owner == OWNER_DATA) ? c_ID_DATA : c_ID_INST;
    assign araddr  = r_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, r_size};
    assign arburst = c_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = (r_state == RD_ADDR);
    assign rready  = (r_state == RD_DATA);

    assign awid    = c_ID_DATA;
    assign awaddr  = r_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, r_size};
    assign awburst = c_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = (r_state == WR_ADDR) && !r_aw_done;

    assign wid    = c_ID_DATA;
    assign wdata  = r_wdata;
    assign wstrb  = size_to_wstrb(r_size, r_addr[1:0]);
    assign wlast  = 1'b1;
    assign wvalid = (r_state == WR_ADDR) && !r_w_done;
    assign bready = (r_state == WR_RESP);

    // Response ids and status are not used: only one transaction is ever in flight.
    assign w_unused = ^{rid, rresp, rlast, bid, bresp};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= OWNER_INST;
            r_addr    <= '0;
            r_size    <= '0;
            r_wdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (data_req) begin
                        r_owner <= OWNER_DATA;
                        r_addr  <= data_addr;
                        r_size  <= data_size;
                        r_wdata <= data_wdata;
                        r_state <= data_wr ? WR_ADDR : RD_ADDR;
                    end else if (inst_req) begin
                        r_owner <= OWNER_INST;
                        r_addr  <= inst_addr;
                        r_size  <= inst_size;
                        r_wdata <= inst_wdata;
                        r_state <= inst_wr ? WR_ADDR : RD_ADDR;
                    end
                end
                RD_ADDR: if (arready) r_state <= RD_DATA;
                RD_DATA: if (rvalid)  r_state <= IDLE;
                WR_ADDR: begin
                    // AW and W complete independently; leave once both have.
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_state   <= WR_RESP;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) r_aw_done <= 1'b1;
                        if (w_w_hs)  r_w_done  <= 1'b1;
                    end
                end
                WR_RESP: if (bvalid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_like_to_axi.sv
// ============================================================================
//  Module      : tb_sram_like_to_axi
//  Description : Self-checking bench for sram_like_to_axi with a data_ok
//                scoreboard and cycle-accurate AXI handshake checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_like_to_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    typedef struct {
        bit          is_data;
        bit          is_read;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    sram_like_to_axi dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Every data_ok must match the oldest accepted, not-yet-completed request.
    always begin
        @(negedge clk);
        #2;
        if (inst_data_ok || data_data_ok) begin
            if (sb.size() == 0) begin
                check("unexpected_data_ok", {inst_data_ok, data_data_ok}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ok_port", {inst_data_ok, data_data_ok}, e.is_data ? 32'h1 : 32'h2);
                if (e.is_read)
                    check("ok_rdata", e.is_data ? data_rdata : inst_rdata, e.rdata);
            end
        end
    end

    task automatic wr_strb(input logic [31:0] a, input logic [1:0] sz, input logic [3:0] exp_strb);
        @(negedge clk);
        data_req = 1; data_wr = 1; data_addr = a; data_size = sz; data_wdata = 32'h5555AAAA;
        awready = 1; wready = 1;
        sb.push_back('{1'b1, 1'b0, 32'h0});
        #1 check("wr_addr_ok", data_addr_ok, 1);
        @(negedge clk);
        data_req = 0;
        #1 check("wstrb", wstrb, exp_strb);
        check("awsize", awsize, {1'b0, sz});
        @(negedge clk);
        bvalid = 1;
        #1 check("wr_bready", bready, 1);
        @(negedge clk);
        bvalid = 0;
    endtask

    initial begin
        rst = 1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 32'hCAFEF00D; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        // Reset state
        @(negedge clk); @(negedge clk);
        #1 check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 32'h0);
        check("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'h0);
        check("rst_inst_rdata", inst_rdata, 32'hCAFEF00D);
        check("rst_data_rdata", data_rdata, 32'hCAFEF00D);
        rst = 0;

        // Data read with immediate handshakes
        @(negedge clk);
        data_req = 1; data_wr = 0; data_addr = 32'h1000_0004; data_size = 2; arready = 1;
        sb.push_back('{1'b1, 1'b1, 32'hDEADBEEF});
        #1 check("rd_addr_ok", {inst_addr_ok, data_addr_ok}, 32'h1);
        check("rd_c0_arvalid", arvalid, 0);
        @(negedge clk);
        data_req = 0;
        #1 check("rd_arvalid", arvalid, 1);
        check("rd_araddr", araddr, 32'h1000_0004);
        check("rd_arid", arid, 1);
        check("rd_arsize", arsize, 3'd2);
        check("rd_c1_data_ok", data_data_ok, 0);
        @(negedge clk);
        arready = 0; rvalid = 1; rdata = 32'hDEADBEEF;
        #1 check("rd_rready", rready, 1);
        check("rd_data_ok", data_data_ok, 1);
        @(negedge clk);
        rvalid = 0;
        #1 check("rd_back_idle", {arvalid, rready, data_data_ok}, 32'h0);

        // Simultaneous requests: data write wins, inst read follows
        inst_req = 1; inst_wr = 0; inst_addr = 32'hBFC0_0000; inst_size = 2;
        data_req = 1; data_wr = 1; data_addr = 32'h8000_0002; data_size = 0; data_wdata = 32'hAA;
        awready = 1; wready = 1;
        sb.push_back('{1'b1, 1'b0, 32'h0});
        #1 check("arb_addr_ok", {inst_addr_ok, data_addr_ok}, 32'h1);
        @(negedge clk);
        data_req = 0;
        #1 check("arb_aw_w_valid", {awvalid, wvalid}, 32'h3);
        check("arb_wstrb", wstrb, 4'b0100);
        check("arb_awsize", awsize, 3'd0);
        check("arb_awaddr", awaddr, 32'h8000_0002);
        check("arb_wdata", wdata, 32'hAA);
        check("arb_inst_wait", inst_addr_ok, 0);
        @(negedge clk);
        awready = 0; wready = 0; bvalid = 1;
        #1 check("arb_bready", bready, 1);
        check("arb_inst_wait2", inst_addr_ok, 0);
        @(negedge clk);
        bvalid = 0;
        sb.push_back('{1'b0, 1'b1, 32'h1234_5678});
        #1 check("arb_inst_accept", {inst_addr_ok, data_addr_ok}, 32'h2);
        @(negedge clk);
        inst_req = 0; arready = 1;
        #1 check("arb_araddr", araddr, 32'hBFC0_0000);
        check("arb_arid", arid, 0);
        @(negedge clk);
        arready = 0; rvalid = 1; rdata = 32'h1234_5678;
        #1 check("arb_inst_data_ok", inst_data_ok, 1);
        @(negedge clk);
        rvalid = 0;

        // Delayed awready, immediate wready
        data_req = 1; data_wr = 1; data_addr = 32'h0000_0100; data_size = 2; data_wdata = 32'h1122_3344;
        awready = 0; wready = 1;
        sb.push_back('{1'b1, 1'b0, 32'h0});
        @(negedge clk);
        data_req = 0;
        #1 check("dly_c1_valids", {awvalid, wvalid}, 32'h3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 check("dly_valids", {awvalid, wvalid, bready}, 32'h4);
            check("dly_awaddr", awaddr, 32'h0000_0100);
        end
        @(negedge clk);
        awready = 1;
        #1 check("dly_c4_valids", {awvalid, wvalid, bready}, 32'h4);
        @(negedge clk);
        awready = 0; wready = 0; bvalid = 1;
        #1 check("dly_resp", {awvalid, wvalid, bready}, 32'h1);
        check("dly_data_ok", data_data_ok, 1);
        @(negedge clk);
        bvalid = 0;

        // Strobe patterns
        wr_strb(32'h0000_0012, 2'd1, 4'b1100);
        wr_strb(32'h0000_0010, 2'd1, 4'b0011);
        wr_strb(32'h0000_0003, 2'd0, 4'b1000);
        wr_strb(32'h0000_0020, 2'd3, 4'b1111);

        // Reset while waiting for read data: transaction is abandoned
        @(negedge clk);
        inst_req = 1; inst_wr = 0; inst_addr = 32'hBFC0_0040; inst_size = 2; arready = 1;
        sb.push_back('{1'b0, 1'b1, 32'h0});
        #1 check("rst_tx_accept", inst_addr_ok, 1);
        @(negedge clk);
        inst_req = 0;
        @(negedge clk);
        arready = 0; rst = 1;
        void'(sb.pop_back());
        #1 check("rst_tx_rready", rready, 1);
        @(negedge clk);
        rst = 0; rvalid = 1; rdata = 32'h0BAD_0BAD;
        #1 check("rst_tx_idle", {rready, arvalid, inst_data_ok, data_data_ok}, 32'h0);
        @(negedge clk);
        rvalid = 0;

        // arready held low: arvalid/araddr stable, no new acceptance
        data_req = 1; data_wr = 0; data_addr = 32'h2000_0008; data_size = 2; arready = 0;
        sb.push_back('{1'b1, 1'b1, 32'hA5A5_5A5A});
        #1 check("stall_accept", data_addr_ok, 1);
        @(negedge clk);
        data_addr = 32'h3000_0000; inst_req = 1; inst_addr = 32'hBFC0_0080;
        for (int i = 0; i < 5; i++) begin
            #1 check("stall_arvalid", arvalid, 1);
            check("stall_araddr", araddr, 32'h2000_0008);
            check("stall_addr_ok", {inst_addr_ok, data_addr_ok}, 32'h0);
            @(negedge clk);
        end
        data_req = 0; inst_req = 0; arready = 1;
        @(negedge clk);
        arready = 0; rvalid = 1; rdata = 32'hA5A5_5A5A;
        #1 check("stall_data_ok", data_data_ok, 1);
        @(negedge clk);
        rvalid = 0;
        @(negedge clk);
        @(negedge clk);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
